ex_addsub_pipe: RTL and testbench



---
 rtl/ex_addsub_pipe.sv | 130 +++++++++++++
 tb/tb_ex_addsub_pipe.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_addsub_pipe.sv
`default_nettype none
// ex_addsub_pipe: pipelined add/subtract whose carry chain is split into STAGES
// equal slices, one slice per stage, with a valid/ready handshake on both sides.
module ex_addsub_pipe #(
  parameter int WIDTH  = 32,  // must be a multiple of STAGES
  parameter int STAGES = 2    // 1..4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] add_in1,
  input  logic [WIDTH-1:0] add_in2,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] add_out,
  output logic             carry_out,
  output logic             ovf,
  output logic             zero
);

  localparam int c_SW = WIDTH / STAGES;

  logic [STAGES-1:0] r_vld;
  logic              w_adv;
  logic [WIDTH-1:0]  r_sum;
  logic              r_cout;
  logic              r_ovf;
  logic              r_zero;

  assign out_valid = r_vld[STAGES-1];
  // Global stall: the whole pipe moves only when the output slot can drain.
  assign in_ready  = !out_valid || out_ready;
  assign w_adv     = in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
    end else if (flush) begin
      r_vld <= '0;
    end else if (w_adv) begin
      r_vld[0] <= in_valid;
      for (int i = 1; i < STAGES; i++) begin
        r_vld[i] <= r_vld[i-1];
      end
    end
  end

  genvar k;
  for (k = 0; k < STAGES; k++) begin : g_stage
    localparam int c_LO = k * c_SW;
    localparam int c_AW = WIDTH - c_LO;

    logic [c_AW-1:0]      w_a;
    logic [c_AW-1:0]      w_b;
    logic                 w_cin;
    logic                 w_u;
    logic [c_SW:0]        w_sum;
    logic [c_LO+c_SW-1:0] w_s;

    if (k == 0) begin : g_first
      // Subtraction is A + ~B + 1; op[0] doubles as the inversion select and carry-in.
      assign w_a   = add_in1;
      assign w_b   = op[0] ? ~add_in2 : add_in2;
      assign w_cin = op[0];
      assign w_u   = op[1];
      assign w_s   = w_sum[c_SW-1:0];
    end else begin : g_next
      assign w_a   = g_stage[k-1].g_mid.r_a;
      assign w_b   = g_stage[k-1].g_mid.r_b;
      assign w_cin = g_stage[k-1].g_mid.r_c;
      assign w_u   = g_stage[k-1].g_mid.r_u;
      assign w_s   = {w_sum[c_SW-1:0], g_stage[k-1].g_mid.r_s};
    end

    assign w_sum = {1'b0, w_a[c_SW-1:0]} + {1'b0, w_b[c_SW-1:0]} + {{c_SW{1'b0}}, w_cin};

    if (k < STAGES - 1) begin : g_mid
      logic [c_AW-c_SW-1:0] r_a;
      logic [c_AW-c_SW-1:0] r_b;
      logic [c_LO+c_SW-1:0] r_s;
      logic                 r_c;
      logic                 r_u;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_a <= '0;
          r_b <= '0;
          r_s <= '0;
          r_c <= 1'b0;
          r_u <= 1'b0;
        end else if (w_adv) begin
          r_a <= w_a[c_AW-1:c_SW];
          r_b <= w_b[c_AW-1:c_SW];
          r_s <= w_s;
          r_c <= w_sum[c_SW];
          r_u <= w_u;
        end
      end
    end else begin : g_last
      logic w_ovf;

      // MSB of the top operand slice is the sign bit of A and of B'.
      assign w_ovf = !w_u && (w_a[c_AW-1] == w_b[c_AW-1]) && (w_s[WIDTH-1] != w_a[c_AW-1]);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_sum  <= '0;
          r_cout <= 1'b0;
          r_ovf  <= 1'b0;
          r_zero <= 1'b0;
        end else if (w_adv) begin
          r_sum  <= w_s;
          r_cout <= w_sum[c_SW];
          r_ovf  <= w_ovf;
          r_zero <= (w_s == '0);
        end
      end
    end
  end

  assign add_out   = out_valid ? r_sum : '0;
  assign carry_out = out_valid && r_cout;
  assign ovf       = out_valid && r_ovf;
  assign zero      = out_valid && r_zero;

endmodule
`default_nettype wire

// File: tb/tb_ex_addsub_pipe.sv
`default_nettype none
// tb_ex_addsub_pipe: directed vector table plus hand-written handshake, flush,
// reset and scoreboarded random sequences for ex_addsub_pipe (32 bits, 2 stages).
module tb_ex_addsub_pipe;

  localparam logic [1:0] c_ADD  = 2'b00;
  localparam logic [1:0] c_SUB  = 2'b01;
  localparam logic [1:0] c_ADDU = 2'b10;
  localparam logic [1:0] c_SUBU = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] add_in1;
  logic [31:0] add_in2;
  logic [1:0]  op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] add_out;
  logic        carry_out;
  logic        ovf;
  logic        zero;

  int n_chk = 0;
  int n_err = 0;

  logic [34:0] exp_q[$];
  logic [34:0] got_q[$];

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sum;
    logic        c;
    logic        v;
    logic        z;
  } vec_t;

  vec_t vecs[11];

  ex_addsub_pipe #(.WIDTH(32), .STAGES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .add_in1   (add_in1),
    .add_in2   (add_in2),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .add_out   (add_out),
    .carry_out (carry_out),
    .ovf       (ovf),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [34:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] yb;
    logic [32:0] s;
    logic        v;
    yb = o[0] ? ~y : y;
    s  = {1'b0, x} + {1'b0, yb} + {32'd0, o[0]};
    v  = !o[1] && (x[31] == yb[31]) && (s[31] != x[31]);
    return {s[31:0], s[32], v, (s[31:0] == 32'd0)};
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 4))
      0:       return 32'h7FFFFFFF;
      1:       return 32'h80000000;
      2:       return 32'hFFFFFFFF;
      3:       return 32'h0000FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: acceptances feed the model queue, consumptions feed the result queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready && !flush) exp_q.push_back(model(op, add_in1, add_in2));
      if (out_valid && out_ready && !flush) got_q.push_back({add_out, carry_out, ovf, zero});
    end
  end

  task automatic run_vec(input vec_t v, input int idx);
    @(posedge clk); #1;
    in_valid = 1'b1; op = v.op; add_in1 = v.a; add_in2 = v.b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk($sformatf("vec%0d_latency_early", idx), out_valid, 1'b0);
    @(negedge clk);
    chk($sformatf("vec%0d_valid", idx), out_valid, 1'b1);
    chk($sformatf("vec%0d_sum", idx), add_out, v.sum);
    chk($sformatf("vec%0d_flags_c_v_z", idx), {carry_out, ovf, zero}, {v.c, v.v, v.z});
  endtask

  initial begin
    logic acc;
    logic seen;

    vecs[0]  = '{c_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{c_ADDU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vecs[2]  = '{c_SUB,  32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{c_SUB,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{c_ADD,  32'h0000FFFF, 32'h00000001, 32'h00010000, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{c_SUBU, 32'h00000007, 32'h00000007, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vecs[6]  = '{c_ADD,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{c_SUBU, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{c_SUB,  32'h00000000, 32'h80000000, 32'h80000000, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{c_ADDU, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{c_ADD,  32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1'b1, 1'b1};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    add_in1 = '0; add_in2 = '0; op = c_ADD;
    repeat (3) @(negedge clk);
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_outputs", {add_out, carry_out, ovf, zero}, 35'd0);
    chk("reset_in_ready", in_ready, 1'b1);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) run_vec(vecs[i], i);
    @(negedge clk);
    chk("idle_valid", out_valid, 1'b0);
    chk("idle_outputs_gated", {add_out, carry_out, ovf, zero}, 35'd0);

    // Back-to-back with a three-cycle output stall.
    got_q.delete(); exp_q.delete();
    out_ready = 1'b0;
    fork
      begin
        for (int t = 1; t <= 3; t++) begin
          @(posedge clk); #1;
          in_valid = 1'b1; op = c_ADD; add_in1 = 32'(t); add_in2 = 32'(t);
          acc = 1'b0;
          for (int w = 0; w < 20 && !acc; w++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
          end
          if (!acc) chk($sformatf("b2b_accept%0d_timeout", t), 1'b0, 1'b1);
          in_valid = 1'b0;
        end
      end
      begin
        seen = 1'b0;
        for (int w = 0; w < 20 && !seen; w++) begin
          @(negedge clk);
          seen = out_valid;
        end
        chk("b2b_first_valid", seen, 1'b1);
        for (int s = 0; s < 3; s++) begin
          chk($sformatf("b2b_stall%0d_in_ready", s), in_ready, 1'b0);
          chk($sformatf("b2b_stall%0d_hold", s), add_out, 32'd2);
          @(posedge clk); #1;
          if (s < 2) @(negedge clk);
        end
        out_ready = 1'b1;
      end
    join
    for (int w = 0; w < 30 && got_q.size() < 3; w++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("b2b_count", got_q.size(), 3);
    for (int i = 0; i < 3 && i < got_q.size(); i++)
      chk($sformatf("b2b_out%0d", i), got_q[i][34:3], 32'(2 * (i + 1)));

    // Flush one cycle after acceptance; the token presented with flush is dropped.
    got_q.delete(); exp_q.delete();
    @(posedge clk); #1;
    in_valid = 1'b1; op = c_ADD; add_in1 = 32'd10; add_in2 = 32'd10;
    @(posedge clk); #1;
    flush = 1'b1; add_in1 = 32'd20; add_in2 = 32'd20;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("flush_no_valid", seen, 1'b0);
    chk("flush_no_result", got_q.size(), 0);

    // Flush overrides a stalled, valid output.
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1; add_in1 = 32'd1; add_in2 = 32'd1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("stall_valid_before_flush", out_valid, 1'b1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_over_stall", out_valid, 1'b0);
    out_ready = 1'b1;

    // Asynchronous reset with two tokens in flight.
    @(posedge clk); #1;
    in_valid = 1'b1; op = c_ADD; add_in1 = 32'd1; add_in2 = 32'd2;
    @(posedge clk); #1;
    add_in1 = 32'd3; add_in2 = 32'd4;
    @(posedge clk); #1;
    in_valid = 1'b0;
    #2;
    chk("inflight_valid", out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_valid", out_valid, 1'b0);
    chk("async_reset_outputs", {add_out, carry_out, ovf, zero}, 35'd0);
    chk("async_reset_in_ready", in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("no_stale_after_reset", seen, 1'b0);
    run_vec(vecs[3], 99);

    // Random traffic against the model with random back-pressure.
    @(posedge clk); #1;
    got_q.delete(); exp_q.delete();
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      op        = 2'($urandom_range(0, 3));
      add_in1   = pick();
      add_in2   = pick();
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int w = 0; w < 50 && got_q.size() < exp_q.size(); w++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("rand_count", got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk($sformatf("rand%0d", i), got_q[i], exp_q[i]);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire
